// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state types and counter width for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_t;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_t;
  function automatic int mdu_cnt_w(int dw);
    return $clog2(dw) + 1;
  endfunction
  localparam int MDU_CNT_W = mdu_cnt_w(32);
endpackage

// File: rtl/mdu.sv
// mdu: iterative RV32M multiply/divide, shift-add multiply and restoring divide
// sharing one DATA_WIDTH+1 adder; div-by-zero and signed overflow finish in one cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int CONTROL_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     StartE,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [CONTROL_WIDTH-1:0] MDUctrl,
  output logic                     BusyE,
  output logic                     DoneE,
  output logic [DATA_WIDTH-1:0]    MDUResult
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = mdu_cnt_w(DATA_WIDTH);
  mdu_state_t state, state_n;
  mdu_op_t op, op_in;
  logic [CW-1:0] cnt;
  logic [W-1:0] opnd, a_mag, b_mag, fast_res, q, r, res;
  logic [2*W-1:0] acc, step, prod;
  logic [W:0] ax, ay, pr, sum;
  logic neg, neg_r, sa, sb, fast, ge;
  assign op_in = mdu_op_t'(MDUctrl[2:0]);
  assign sa = (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && SrcA[W-1];
  assign sb = (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM}) && SrcB[W-1];
  assign a_mag = sa ? -SrcA : SrcA;
  assign b_mag = sb ? -SrcB : SrcB;
  // Overflow quotient is the most-negative value, which is SrcA itself
  assign fast = op_in[2] && (SrcB == '0 ||
                (!op_in[0] && SrcA == {1'b1, {(W-1){1'b0}}} && &SrcB));
  assign fast_res = (SrcB == '0) ? (op_in[1] ? SrcA : '1) : (op_in[1] ? '0 : SrcA);
  // Divide: acc = {remainder, dividend/quotient}; multiply: acc = {high, low/multiplier}
  assign pr = acc[2*W-1:W-1];
  assign ax = op[2] ? pr : {1'b0, acc[2*W-1:W]};
  assign ay = op[2] ? ~{1'b0, opnd} : {1'b0, acc[0] ? opnd : '0};
  assign {ge, sum} = {1'b0, ax} + {1'b0, ay} + {{(W+1){1'b0}}, op[2]};
  assign step = op[2] ? {ge ? sum[W-1:0] : pr[W-1:0], acc[W-2:0], ge} : {sum, acc[W-1:1]};
  assign prod = neg ? -step : step;
  assign q = step[W-1:0];
  assign r = step[2*W-1:W];
  assign res = op[2] ? (op[1] ? (neg_r ? -r : r) : (neg ? -q : q))
                     : (op == OP_MUL ? prod[W-1:0] : prod[2*W-1:W]);
  assign BusyE = (state == IDLE && StartE) || state == CALC;
  assign DoneE = state == DONE;
  always_comb begin
    state_n = state == IDLE ? (StartE ? (fast ? DONE : CALC) : IDLE) :
              state == CALC ? (cnt == CW'(1) ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op <= OP_MUL;
      neg <= 1'b0;
      neg_r <= 1'b0;
      cnt <= '0;
      opnd <= '0;
      acc <= '0;
      MDUResult <= '0;
    end else if (state == IDLE && StartE) begin
      op <= op_in;
      neg <= sa ^ sb;
      neg_r <= sa;
      cnt <= CW'(W);
      opnd <= op_in[2] ? b_mag : a_mag;
      acc <= {{W{1'b0}}, op_in[2] ? a_mag : b_mag};
      if (fast) MDUResult <= fast_res;
    end else if (state == CALC) begin
      acc <= step;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) MDUResult <= res;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: randomized scoreboard bench for mdu against a plain-arithmetic RV32M model
module tb_mdu;
  logic clk = 1'b0;
  logic rst, StartE, BusyE, DoneE;
  logic [31:0] SrcA, SrcB, MDUResult;
  logic [2:0] MDUctrl;
  int cyc = 0;
  int pass_n = 0;
  int tot_n = 0;
  typedef struct {
    logic [31:0] res;
    int          at;
  } exp_t;
  exp_t sbq[$];

  mdu #(.DATA_WIDTH(32), .CONTROL_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .StartE(StartE), .SrcA(SrcA), .SrcB(SrcB),
    .MDUctrl(MDUctrl), .BusyE(BusyE), .DoneE(DoneE), .MDUResult(MDUResult)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tot_n++;
    if (got === want) pass_n++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, got, want, cyc);
  endtask

  function automatic logic [31:0] model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, x;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: x = sa * sb;
      3'd1: x = (sa * sb) >>> 32;
      3'd2: x = (sa * ub) >>> 32;
      3'd3: x = longint'((64'(ua) * 64'(ub)) >> 32);
      3'd4: x = (b == 0) ? -1 : sa / sb;
      3'd5: x = (b == 0) ? -1 : ua / ub;
      3'd6: x = (b == 0) ? ua : sa % sb;
      default: x = (b == 0) ? ua : ua % ub;
    endcase
    return x[31:0];
  endfunction

  function automatic bit is_fast(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Scoreboard monitor: every DoneE pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && DoneE) begin
      if (sbq.size() == 0) begin
        tot_n++;
        $display("FAIL unexpected_done: got DoneE=1 want no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("result", MDUResult, e.res);
        check("done_cycle", 32'(cyc), 32'(e.at));
        check("busy_in_done", {31'b0, BusyE}, 32'd0);
      end
    end
  end

  // Called at a negedge with the unit idle; returns at a negedge with it idle again
  task automatic issue(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int busy_n, n;
    bit f;
    f = is_fast(op, a, b);
    MDUctrl = op;
    SrcA = a;
    SrcB = b;
    StartE = 1'b1;
    #1 check("busy_request", {31'b0, BusyE}, 32'd1);
    @(posedge clk);
    #1;
    sbq.push_back('{model(op, a, b), cyc + (f ? 0 : 32)});
    StartE = 1'b0;
    busy_n = 0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (DoneE) break;
      if (BusyE) busy_n++;
      n++;
    end
    if (n >= 40) begin
      tot_n++;
      $display("FAIL done_timeout: got no DoneE want DoneE within 40 cycles (op %0d)", op);
      sbq.delete();
    end
    check("busy_cycles", 32'(busy_n), f ? 32'd0 : 32'd32);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1);
  end

  initial begin
    int e;
    logic [31:0] first;
    rst = 1'b1;
    StartE = 1'b0;
    SrcA = '0;
    SrcB = '0;
    MDUctrl = '0;
    repeat (2) @(negedge clk);
    check("reset_result", MDUResult, 32'd0);
    check("reset_done", {31'b0, DoneE}, 32'd0);
    check("reset_busy", {31'b0, BusyE}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // Directed cases
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);
    issue(3'd5, 32'd100, 32'd7);
    issue(3'd7, 32'd100, 32'd7);
    issue(3'd5, 32'd5, 32'd0);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd7, 32'h1234_5678, 32'd0);
    // Randomized mix including zero divisors and overflow operands
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      int mode;
      mode = $urandom_range(5);
      a = $urandom;
      b = $urandom;
      if (mode == 0) b = 32'd0;
      if (mode == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (mode == 2) begin
        a = $urandom_range(300);
        b = $urandom_range(20);
      end
      issue(3'($urandom_range(7)), a, b);
    end
    // StartE held high: second op accepted right after DONE, result held meanwhile
    MDUctrl = 3'd4;
    SrcA = 32'hFFFF_FF9C;
    SrcB = 32'd7;
    StartE = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    first = model(3'd4, 32'hFFFF_FF9C, 32'd7);
    sbq.push_back('{first, e + 32});
    sbq.push_back('{model(3'd5, 32'd1000, 32'd9), e + 66});
    MDUctrl = 3'd5;
    SrcA = 32'd1000;
    SrcB = 32'd9;
    repeat (40) @(negedge clk);
    check("result_hold", MDUResult, first);
    repeat (15) @(negedge clk);
    StartE = 1'b0;
    repeat (20) @(negedge clk);
    check("held_start_drained", 32'(sbq.size()), 32'd0);
    // Reset during a multiply discards it
    MDUctrl = 3'd0;
    SrcA = 32'd12345;
    SrcB = 32'd678;
    StartE = 1'b1;
    @(posedge clk);
    #1 StartE = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_result", MDUResult, 32'd0);
    check("rst_busy", {31'b0, BusyE}, 32'd0);
    check("rst_done", {31'b0, DoneE}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_no_result", MDUResult, 32'd0);
    issue(3'd5, 32'd9, 32'd3);
    check("final_queue_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
